// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one outstanding imem read at a time, redirect handling
// with in-flight response discard, and a sticky halt on a misaligned redirect.
module ysyx_25020047_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] snpc,
   output logic        fetch_err
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic        discard, discard_n;
   logic        fetch_err_n;
   logic        capture;

   always_comb begin
      state_n     = state;
      fetch_pc_n  = fetch_pc;
      discard_n   = discard;
      fetch_err_n = fetch_err;
      capture     = 1'b0;

      case (state)
         IDLE: state_n = REQ;
         REQ:  if (imem_req_ready) state_n = WAIT;
         WAIT: begin
            if (imem_resp_valid) begin
               if (discard) begin
                  discard_n = 1'b0;
                  state_n   = REQ;
               end else begin
                  capture    = 1'b1;
                  fetch_pc_n = fetch_pc + 32'd4;
                  state_n    = HOLD;
               end
            end
         end
         HOLD: if (inst_ready) state_n = REQ;
         HALT: ;
         default: state_n = IDLE;
      endcase

      // A redirect overrides whatever the normal flow decided above.
      if (redirect_valid && state != HALT) begin
         capture = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            state_n     = HALT;
            fetch_err_n = 1'b1;
            discard_n   = 1'b0;
            fetch_pc_n  = fetch_pc;
         end else begin
            fetch_pc_n = redirect_pc;
            case (state)
               REQ:  if (imem_req_ready) discard_n = 1'b1;
               WAIT: begin
                  if (imem_resp_valid) begin
                     discard_n = 1'b0;
                     state_n   = REQ;
                  end else begin
                     discard_n = 1'b1;
                  end
               end
               HOLD: state_n = REQ;
               default: ;
            endcase
         end
      end
   end

   // Outputs are registered copies of the next-state decisions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         fetch_pc       <= RESET_PC;
         discard        <= 1'b0;
         fetch_err      <= 1'b0;
         imem_req_valid <= 1'b0;
         imem_req_addr  <= RESET_PC;
         inst_valid     <= 1'b0;
         inst           <= 32'h0000_0013;
         pc             <= RESET_PC;
         snpc           <= RESET_PC + 32'd4;
      end else begin
         state          <= state_n;
         fetch_pc       <= fetch_pc_n;
         discard        <= discard_n;
         fetch_err      <= fetch_err_n;
         imem_req_valid <= (state_n == REQ);
         imem_req_addr  <= fetch_pc_n;
         inst_valid     <= (state_n == HOLD);
         if (capture) begin
            inst <= imem_resp_data;
            pc   <= fetch_pc;
            snpc <= fetch_pc_n;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed table-driven bench for the fetch unit plus reset corner sequences.
module tb_ysyx_25020047_ifu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] snpc;
   logic        fetch_err;

   int errors = 0;
   int checks = 0;

   ysyx_25020047_ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .pc(pc), .snpc(snpc), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdv;
      logic [31:0] rdpc;
      logic        rdy;
      logic        rsv;
      logic [31:0] rsd;
      logic        ird;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic [31:0] e_snpc;
      logic        e_err;
   } vec_t;

   localparam int NV = 27;
   vec_t vec [NV];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step%0d %s: got %h want %h", idx, name, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic rv, input logic [31:0] addr, input logic iv,
                          input logic [31:0] ins, input logic [31:0] p, input logic [31:0] sp,
                          input logic err);
      chk("imem_req_valid", idx, {31'h0, imem_req_valid}, {31'h0, rv});
      chk("imem_req_addr",  idx, imem_req_addr, addr);
      chk("inst_valid",     idx, {31'h0, inst_valid}, {31'h0, iv});
      chk("inst",           idx, inst, ins);
      chk("pc",             idx, pc, p);
      chk("snpc",           idx, snpc, sp);
      chk("fetch_err",      idx, {31'h0, fetch_err}, {31'h0, err});
   endtask

   task automatic drive(input logic rdv, input logic [31:0] rdpc, input logic rdy,
                        input logic rsv, input logic [31:0] rsd, input logic ird);
      redirect_valid  = rdv;
      redirect_pc     = rdpc;
      imem_req_ready  = rdy;
      imem_resp_valid = rsv;
      imem_resp_data  = rsd;
      inst_ready      = ird;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] B0  = 32'h8000_0000;
   localparam logic [31:0] B4  = 32'h8000_0004;

   initial begin
      //           rdv  rdpc          rdy  rsv  rsd           ird  rv   addr          iv   inst          pc            snpc          err
      vec[0]  = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b1,B0,           1'b0,NOP,          B0,           B4,           1'b0};
      vec[1]  = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,B0,           1'b0,NOP,          B0,           B4,           1'b0};
      vec[2]  = '{1'b0, 32'h0,        1'b1,1'b1,32'h0000_0093,1'b0,1'b0,B4,           1'b1,32'h93,       B0,           B4,           1'b0};
      for (int i = 3; i < 8; i++)
         vec[i] = '{1'b0, 32'h0,      1'b1,1'b1,32'hFFFF_FFFF,1'b0,1'b0,B4,           1'b1,32'h93,       B0,           B4,           1'b0};
      vec[8]  = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        1'b1,1'b1,B4,           1'b0,32'h93,       B0,           B4,           1'b0};
      vec[9]  = '{1'b0, 32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b1,B4,           1'b0,32'h93,       B0,           B4,           1'b0};
      vec[10] = '{1'b1, 32'h8000_0100,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h8000_0100,1'b0,32'h93,       B0,           B4,           1'b0};
      vec[11] = '{1'b0, 32'h0,        1'b0,1'b0,32'h0,        1'b0,1'b0,32'h8000_0100,1'b0,32'h93,       B0,           B4,           1'b0};
      vec[12] = '{1'b0, 32'h0,        1'b0,1'b1,32'hDEAD_BEEF,1'b0,1'b1,32'h8000_0100,1'b0,32'h93,       B0,           B4,           1'b0};
      vec[13] = '{1'b1, 32'h8000_0200,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h8000_0200,1'b0,32'h93,       B0,           B4,           1'b0};
      vec[14] = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h8000_0200,1'b0,32'h93,       B0,           B4,           1'b0};
      vec[15] = '{1'b0, 32'h0,        1'b0,1'b1,32'h0010_0073,1'b0,1'b0,32'h8000_0204,1'b1,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[16] = '{1'b1, 32'h8000_0040,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h8000_0040,1'b0,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[17] = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h8000_0040,1'b0,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[18] = '{1'b1, 32'h8000_0080,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h8000_0080,1'b0,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[19] = '{1'b0, 32'h0,        1'b0,1'b1,32'h1111_1111,1'b0,1'b1,32'h8000_0080,1'b0,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[20] = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'h8000_0080,1'b0,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[21] = '{1'b1, 32'hFFFF_FFFC,1'b0,1'b1,32'h2222_2222,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[22] = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,1'b0,32'hFFFF_FFFC,1'b0,32'h0010_0073,32'h8000_0200,32'h8000_0204,1'b0};
      vec[23] = '{1'b0, 32'h0,        1'b0,1'b1,32'h3333_3333,1'b0,1'b0,32'h0000_0000,1'b1,32'h3333_3333,32'hFFFF_FFFC,32'h0000_0000,1'b0};
      vec[24] = '{1'b0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0000_0000,1'b0,32'h3333_3333,32'hFFFF_FFFC,32'h0000_0000,1'b0};
      vec[25] = '{1'b1, 32'h8000_0042,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0000,1'b0,32'h3333_3333,32'hFFFF_FFFC,32'h0000_0000,1'b1};
      vec[26] = '{1'b1, 32'h8000_0000,1'b1,1'b1,32'h4444_4444,1'b1,1'b0,32'h0000_0000,1'b0,32'h3333_3333,32'hFFFF_FFFC,32'h0000_0000,1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk_all(-1, 1'b0, B0, 1'b0, NOP, B0, B4, 1'b0);
      rst = 1'b1;
      chk_all(-2, 1'b0, B0, 1'b0, NOP, B0, B4, 1'b0);

      for (int i = 0; i < NV; i++) begin
         drive(vec[i].rdv, vec[i].rdpc, vec[i].rdy, vec[i].rsv, vec[i].rsd, vec[i].ird);
         @(posedge clk);
         #1;
         chk_all(i, vec[i].e_rv, vec[i].e_addr, vec[i].e_iv, vec[i].e_inst,
                 vec[i].e_pc, vec[i].e_snpc, vec[i].e_err);
      end

      // Asynchronous reset out of HALT, checked before any clock edge.
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      #1;
      chk_all(100, 1'b0, B0, 1'b0, NOP, B0, B4, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_all(101, 1'b1, B0, 1'b0, NOP, B0, B4, 1'b0);
      @(posedge clk); #1;
      chk_all(102, 1'b0, B0, 1'b0, NOP, B0, B4, 1'b0);

      // Reset while a request is outstanding; a response asserted afterwards is ignored.
      rst = 1'b0;
      #1;
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555, 1'b1);
      @(posedge clk); #1;
      chk_all(103, 1'b1, B0, 1'b0, NOP, B0, B4, 1'b0);
      @(posedge clk); #1;
      chk_all(104, 1'b1, B0, 1'b0, NOP, B0, B4, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0093, 1'b0);
      @(posedge clk); #1;
      chk_all(105, 1'b0, B4, 1'b1, 32'h93, B0, B4, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_25020047_ifu.md
YSYX_25020047_IFU -- requirements
Module: ysyx_25020047_IFU

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000: the address of the first fetch after reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port redirect_valid  input  1  the next fetch address is replaced by redirect_pc.
REQ-005 The block SHALL have port redirect_pc  input  32  the redirect target (dnpc from execute).
REQ-006 The block SHALL have port imem_req_valid  output  1  an instruction-memory read request is pending.
REQ-007 The block SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 The block SHALL have port imem_req_addr  output  32  the word-aligned fetch address.
REQ-009 The block SHALL have port imem_resp_valid  input  1  imem_resp_data is valid this cycle.
REQ-010 The block SHALL have port imem_resp_data  input  32  the fetched instruction word.
REQ-011 The block SHALL have port inst_valid  output  1  inst/pc/snpc hold a deliverable instruction for decode.
REQ-012 The block SHALL have port inst_ready  input  1  decode consumes the instruction this cycle.
REQ-013 The block SHALL have port inst  output  32  the instruction word for decode.
REQ-014 The block SHALL have port pc  output  32  the address of inst.
REQ-015 The block SHALL have port snpc  output  32  pc+4.
REQ-016 The block SHALL have port fetch_err  output  1  sticky flag for a misaligned redirect.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and HALT; an internal register fetch_pc holds the next fetch address, and a discard flag marks an in-flight response to be dropped.
REQ-018 IDLE SHALL advance to REQ unconditionally on the next cycle, with imem_req_valid=0 while in IDLE.
REQ-019 In REQ, imem_req_valid SHALL be 1 and imem_req_addr SHALL equal fetch_pc; the FSM SHALL move to WAIT when imem_req_ready=1.
REQ-020 imem_req_valid and imem_req_addr SHALL stay stable in REQ until accepted, except on a redirect.
REQ-021 The block SHALL allow at most one outstanding request.
REQ-022 In WAIT with imem_resp_valid=1 and discard=0, the block SHALL register inst<=imem_resp_data, pc<=fetch_pc and snpc<=fetch_pc+4, set inst_valid=1, set fetch_pc<=fetch_pc+4 (mod 2^32, wrapping 32'hFFFF_FFFC to 0), and move to HOLD.
REQ-023 In WAIT with imem_resp_valid=1 and discard=1, the block SHALL drop the response, clear discard, and move to REQ.
REQ-024 In HOLD, inst_valid SHALL be 1 and inst/pc/snpc SHALL be stable; on inst_ready=1 the block SHALL clear inst_valid and move to REQ.
REQ-025 Minimum throughput SHALL be one instruction per 3 cycles with zero memory latency: REQ→WAIT→HOLD.
REQ-026 imem_resp_valid SHALL be ignored outside WAIT.
REQ-027 inst_ready SHALL be ignored outside HOLD.
REQ-028 Redirect SHALL have priority over every other event, with aligned redirect_pc[1:0]=0: fetch_pc<=redirect_pc in every state except HALT.
REQ-029 A redirect in REQ without a handshake SHALL leave the FSM in REQ, and the next cycle's imem_req_addr SHALL be redirect_pc.
REQ-030 A redirect in REQ in the same cycle as the handshake SHALL move the FSM to WAIT with discard=1.
REQ-031 A redirect in WAIT without a response SHALL set discard=1 and keep the FSM in WAIT.
REQ-032 A redirect in WAIT with a response in the same cycle SHALL drop the response and move the FSM to REQ with discard=0.
REQ-033 A redirect in HOLD SHALL clear inst_valid next cycle and move the FSM to REQ, regardless of inst_ready; the block SHALL NOT mask inst_valid combinationally.
REQ-034 A redirect with redirect_pc[1:0]≠0 SHALL set fetch_err=1 and move the FSM to HALT.
REQ-035 In HALT, imem_req_valid and inst_valid SHALL be 0, all inputs SHALL be ignored, and only reset exits HALT.
REQ-036 All outputs SHALL be driven from registers, with no combinational input-to-output paths.

Reset
REQ-037 On rst=0, asynchronously: state=IDLE, fetch_pc=RESET_PC, discard=0, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (nop), pc=RESET_PC, snpc=RESET_PC+4, fetch_err=0.
REQ-038 Reset mid-transaction SHALL abandon any outstanding request; instruction memory shares rst, so no stale response follows reset.

Verification
REQ-039 Reset release, memory always ready with 0-cycle response of 32'h0000_0093 → first request addr 32'h8000_0000; inst_valid rises at cycle 3 with pc=32'h8000_0000, snpc=32'h8000_0004; the next request addr is 32'h8000_0004.
REQ-040 inst_ready held 0 for 5 cycles in HOLD → inst, pc and inst_valid stable, imem_req_valid=0 throughout; inst_ready=1 → REQ next cycle.
REQ-041 Redirect to 32'h8000_0100 in the same cycle as a REQ handshake; response 32'hDEAD_BEEF arrives 2 cycles later → response dropped, inst_valid stays 0; the next request addr is 32'h8000_0100.
REQ-042 Redirect to 32'h8000_0040 in HOLD with inst_ready=1 → inst_valid=0 next cycle, imem_req_addr=32'h8000_0040.
REQ-043 Redirect to 32'h8000_0042 → fetch_err=1 next cycle, no further requests; rst pulse → fetch_err=0, fetch restarts at RESET_PC.
REQ-044 fetch_pc=32'hFFFF_FFFC delivered → the next request addr is 32'h0000_0000.
